// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide/remainder unit.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam int unsigned DIV_ITER = 32;
  localparam int unsigned CNT_W    = $clog2(DIV_ITER);

  function automatic logic op_is_signed(div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign handling: operand magnitudes at accept, result
// negation when the last quotient bit is produced.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic [XLEN-1:0] o_abs_a,
  output logic [XLEN-1:0] o_abs_b,
  output logic            o_neg_quo,
  output logic            o_neg_rem,
  input  logic [1:0]      i_res_op,
  input  logic            i_res_neg_quo,
  input  logic            i_res_neg_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_rem,
  output logic [XLEN-1:0] o_result
);

  logic            a_neg;
  logic            b_neg;
  logic            res_neg;
  logic [XLEN-1:0] res_sel;

  always_comb begin
    a_neg     = op_is_signed(div_op_e'(i_op)) & i_op_a[XLEN-1];
    b_neg     = op_is_signed(div_op_e'(i_op)) & i_op_b[XLEN-1];
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    o_abs_a   = a_neg ? -i_op_a : i_op_a;
    o_abs_b   = b_neg ? -i_op_b : i_op_b;
    o_neg_quo = a_neg ^ b_neg;
    o_neg_rem = a_neg;

    if (op_is_rem(div_op_e'(i_res_op))) begin
      res_sel = i_rem;
      res_neg = i_res_neg_rem;
    end else begin
      res_sel = i_quo;
      res_neg = i_res_neg_quo;
    end
    o_result = res_neg ? -res_sel : res_sel;
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring division,
// one quotient bit per cycle, valid/ready request and response channels.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic [1:0]      i_div_op,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_div_data,
  output logic            o_busy
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  div_op_e          op_q, op_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]  res_q, res_d;

  logic [XLEN-1:0]  abs_a, abs_b;
  logic             in_neg_quo, in_neg_rem;
  logic [XLEN-1:0]  fix_result;

  logic [XLEN:0]    rem_sh;
  logic [XLEN:0]    trial;
  logic             trial_ge;
  logic [XLEN-1:0]  rem_it, quo_it;
  logic             accept;
  logic             div_by_zero;
  logic             overflow;

  div_sign_fix #(
    .XLEN(XLEN)
  ) u_sign_fix (
    .i_op         (i_div_op),
    .i_op_a       (i_op_a),
    .i_op_b       (i_op_b),
    .o_abs_a      (abs_a),
    .o_abs_b      (abs_b),
    .o_neg_quo    (in_neg_quo),
    .o_neg_rem    (in_neg_rem),
    .i_res_op     (op_q),
    .i_res_neg_quo(neg_quo_q),
    .i_res_neg_rem(neg_rem_q),
    .i_quo        (quo_it),
    .i_rem        (rem_it),
    .o_result     (fix_result)
  );

  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    trial    = rem_sh - {1'b0, dvs_q};
    trial_ge = ~trial[XLEN];
    rem_it   = trial_ge ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_it   = {quo_q[XLEN-2:0], trial_ge};

    accept      = i_req_valid & (state_q == IDLE);
    div_by_zero = (i_op_b == '0);
    overflow    = op_is_signed(div_op_e'(i_div_op)) & (i_op_a == INT_MIN) & (i_op_b == '1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = div_op_e'(i_div_op);
          if (div_by_zero) begin
            res_d   = op_is_rem(div_op_e'(i_div_op)) ? i_op_a : '1;
            state_d = DONE;
          end else if (overflow) begin
            res_d   = op_is_rem(div_op_e'(i_div_op)) ? '0 : INT_MIN;
            state_d = DONE;
          end else begin
            rem_d     = '0;
            quo_d     = abs_a;
            dvs_d     = abs_b;
            neg_quo_d = in_neg_quo;
            neg_rem_d = in_neg_rem;
            cnt_d     = '0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_it;
        quo_d = quo_it;
        cnt_d = cnt_q + CNT_W'(1);
        // Sign fix-up is applied to the final iteration's values on the same edge.
        if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
          res_d   = fix_result;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_rsp_ready) begin
          res_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      op_q      <= DIV;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_q     <= res_d;
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == DONE);
  assign o_busy      = (state_q != IDLE);
  assign o_div_data  = (state_q == DONE) ? res_q : '0;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed test-plan cases, randomized
// operations against an arithmetic reference model, backpressure and reset.
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic [1:0]  i_div_op;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_div_data;
  logic        o_busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_q[$];

  div_unit #(
    .XLEN(32)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_op_a     (i_op_a),
    .i_op_b     (i_op_b),
    .i_div_op   (i_div_op),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_div_data (o_div_data),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (!rst && i_req_valid && o_req_ready) acc_q.push_back(cyc);
  end

  // RISC-V M semantics from plain 64-bit arithmetic (truncating division).
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x, y, q, r;
    logic   sgn, is_rem;
    sgn    = (op == DIV) || (op == REM);
    is_rem = (op == REM) || (op == REMU);
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return is_rem ? 32'(r) : 32'(q);
  endfunction

  // Edges after the accept edge until o_rsp_valid is first seen.
  function automatic int ref_edges(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    logic sgn;
    sgn = (op == DIV) || (op == REM);
    if (b == 32'd0) return 0;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    n_cmp++;
    if (o_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_ready: got %b want 1", o_req_ready);
    end
    i_req_valid = 1'b1;
    i_div_op    = op;
    i_op_a      = a;
    i_op_b      = b;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_op_a      = $urandom;
    i_op_b      = $urandom;
    i_div_op    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_rsp(output int edges);
    edges = 0;
    while (!o_rsp_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int          edges;
    logic [31:0] exp_data;
    int          exp_edges;
    exp_data  = ref_div(op, a, b);
    exp_edges = ref_edges(op, a, b);
    issue(op, a, b);
    wait_rsp(edges);
    n_cmp++;
    if (edges !== exp_edges) begin
      n_err++;
      $display("FAIL %s_latency: got %0d edges want %0d", tag, edges, exp_edges);
    end
    n_cmp++;
    if (o_div_data !== exp_data) begin
      n_err++;
      $display("FAIL %s_data: op=%0d a=%h b=%h got %h want %h", tag, op, a, b, o_div_data,
               exp_data);
    end
    @(negedge clk);
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    i_rsp_ready = 1'b0;
    n_cmp++;
    if ({o_req_ready, o_rsp_valid, o_busy, o_div_data} !== {3'b100, 32'd0}) begin
      n_err++;
      $display("FAIL %s_idle: got rdy=%b vld=%b busy=%b data=%h want 1 0 0 0", tag,
               o_req_ready, o_rsp_valid, o_busy, o_div_data);
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    i_op_a      = '0;
    i_op_b      = '0;
    i_div_op    = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_req_ready, o_rsp_valid, o_busy, o_div_data} !== {3'b100, 32'd0}) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b vld=%b busy=%b data=%h want 1 0 0 0",
               o_req_ready, o_rsp_valid, o_busy, o_div_data);
    end
    @(negedge clk);
    rst         = 1'b0;
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_directed();
    run_op(DIVU, 32'd100, 32'd7, "divu_100_7");
    run_op(REMU, 32'd100, 32'd7, "remu_100_7");
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(REM, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_op(REM, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
    run_op(DIVU, 32'h1234_5678, 32'd0, "divu_by0");
    run_op(REM, 32'h1234_5678, 32'd0, "rem_by0");
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(DIVU, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    run_op(DIV, 32'h8000_0000, 32'd1, "div_min_1");
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = b >> $urandom_range(0, 31);
        1: b = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = a >> $urandom_range(0, 31);
        4: b = 32'(-int'($urandom_range(1, 20)));
        default: ;
      endcase
      run_op(op, a, b, "random");
    end
  endtask

  task automatic test_backpressure();
    int          edges;
    logic [31:0] exp_data;
    exp_data = ref_div(DIV, 32'hFFFF_FC18, 32'd7);
    issue(DIV, 32'hFFFF_FC18, 32'd7);
    wait_rsp(edges);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i_req_valid = 1'($urandom_range(0, 1));
      i_op_a      = $urandom;
      i_op_b      = $urandom_range(1, 9);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({o_rsp_valid, o_req_ready, o_div_data} !== {2'b10, exp_data}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b data=%h want 1 0 %h", i, o_rsp_valid,
                 o_req_ready, o_div_data, exp_data);
      end
    end
    @(negedge clk);
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    i_rsp_ready = 1'b0;
    n_cmp++;
    if ({o_req_ready, o_rsp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", o_req_ready, o_rsp_valid);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_accept: got busy=%b want 0", o_busy);
    end
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    issue(DIVU, 32'hDEAD_BEEF, 32'd13);
    repeat (14) @(posedge clk);
    #3;
    i_rsp_ready = 1'b1;
    rst         = 1'b1;
    #1;
    n_cmp++;
    if ({o_req_ready, o_rsp_valid, o_busy, o_div_data} !== {3'b100, 32'd0}) begin
      n_err++;
      $display("FAIL reset_async: got rdy=%b vld=%b busy=%b data=%h want 1 0 0 0",
               o_req_ready, o_rsp_valid, o_busy, o_div_data);
    end
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (o_rsp_valid || o_busy) seen++;
    end
    i_rsp_ready = 1'b0;
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL reset_no_stale: got %0d active cycles want 0", seen);
    end
    run_op(DIVU, 32'd9, 32'd3, "post_reset");
  endtask

  task automatic test_back_to_back();
    int          got;
    int          guard;
    logic [31:0] exp_data;
    exp_data = ref_div(DIVU, 32'd1000, 32'd7);
    got      = 0;
    guard    = 0;
    acc_q.delete();
    @(negedge clk);
    i_req_valid = 1'b1;
    i_div_op    = DIVU;
    i_op_a      = 32'd1000;
    i_op_b      = 32'd7;
    i_rsp_ready = 1'b1;
    while (acc_q.size() < 3 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (o_rsp_valid) begin
        got++;
        n_cmp++;
        if (o_div_data !== exp_data) begin
          n_err++;
          $display("FAIL b2b_data: got %h want %h", o_div_data, exp_data);
        end
      end
    end
    i_req_valid = 1'b0;
    guard = 0;
    while (o_busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    i_rsp_ready = 1'b0;
    n_cmp++;
    if (acc_q.size() < 3 || got !== 2) begin
      n_err++;
      $display("FAIL b2b_count: got %0d accepts %0d responses want 3 2", acc_q.size(), got);
    end else begin
      n_cmp++;
      if (acc_q[1] - acc_q[0] !== 34 || acc_q[2] - acc_q[1] !== 34) begin
        n_err++;
        $display("FAIL b2b_interval: got %0d,%0d want 34,34", acc_q[1] - acc_q[0],
                 acc_q[2] - acc_q[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
